// File: rtl/mux_rr_sched.sv
// mux_rr_sched: round-robin scheduler for four requesters sharing one nibble
// channel. Grants are packet-atomic, a beat limit forces rotation, and the
// selected nibble is presented through a registered valid/ready output stage.
module mux_rr_sched #(
    parameter int unsigned MAX_BURST = 8
) (
    input  logic        inClk,
    input  logic        inRstn,
    input  logic [3:0]  inReq,
    input  logic [15:0] inData,
    input  logic [3:0]  inLast,
    input  logic        inReady,
    output logic [3:0]  outAck,
    output logic [3:0]  outGnt,
    output logic [1:0]  outSel,
    output logic [3:0]  outData,
    output logic        outValid,
    output logic        outBusy
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] XFER = 1'b1;
    localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

    logic [0:0] state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       can_load_s;
    logic       accept_s;
    logic       release_s;
    logic [3:0] lane_s;

    // First set request bit searching ptr+1, ptr+2, ptr+3, ptr (mod 4).
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic       found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    // 4:1 nibble multiplexer driven by the registered select.
    function automatic logic [3:0] lane_pick(input logic [15:0] data, input logic [1:0] idx);
        case (idx)
            2'd0:    lane_pick = data[3:0];
            2'd1:    lane_pick = data[7:4];
            2'd2:    lane_pick = data[11:8];
            2'd3:    lane_pick = data[15:12];
            default: lane_pick = 4'h0;
        endcase
    endfunction

    function automatic logic [3:0] one_hot(input logic [1:0] idx);
        one_hot = 4'b0001 << idx;
    endfunction

    // The output register may load when empty or being consumed this cycle.
    assign can_load_s = !valid_q || inReady;
    assign accept_s   = (state_q == XFER) && inReq[sel_q] && can_load_s;
    assign release_s  = accept_s && (inLast[sel_q] || ((cnt_q + 8'd1) == MAX_BURST_C));
    assign lane_s     = lane_pick(inData, sel_q);

    assign outAck   = accept_s ? one_hot(sel_q) : 4'b0000;
    assign outGnt   = gnt_q;
    assign outSel   = sel_q;
    assign outData  = data_q;
    assign outValid = valid_q;
    assign outBusy  = (state_q == XFER);

    // Next-state logic: arbitration in IDLE, beat transfer and release in XFER.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        data_d  = data_q;
        // Drain a consumed beat unless a new one replaces it below.
        if (valid_q && inReady) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        case (state_q)
            IDLE: begin
                if (inReq != 4'b0000) begin
                    sel_d   = rr_pick(inReq, ptr_q);
                    gnt_d   = one_hot(rr_pick(inReq, ptr_q));
                    cnt_d   = 8'd0;
                    state_d = XFER;
                end else begin
                    gnt_d   = 4'b0000;
                end
            end
            XFER: begin
                if (accept_s) begin
                    data_d  = lane_s;
                    valid_d = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                    if (release_s) begin
                        ptr_d   = sel_q;
                        gnt_d   = 4'b0000;
                        state_d = IDLE;
                    end else begin
                        state_d = XFER;
                    end
                end else begin
                    // Grant and counter hold through stalls and backpressure.
                    state_d = XFER;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    // State and output registers; reset leaves requester 0 at top priority.
    always_ff @(posedge inClk or negedge inRstn) begin
        if (!inRstn) begin
            state_q <= IDLE;
            ptr_q   <= 2'd3;
            cnt_q   <= 8'd0;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            data_q  <= 4'h0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_mux_rr_sched.sv
// Self-checking bench for mux_rr_sched: directed scenarios plus random traffic,
// each cycle compared against a packet/queue-level reference model.
module tb_mux_rr_sched;

    localparam int MAXB = 8;

    logic        inClk = 1'b0;
    logic        inRstn;
    logic [3:0]  inReq;
    logic [15:0] inData;
    logic [3:0]  inLast;
    logic        inReady;
    logic [3:0]  outAck;
    logic [3:0]  outGnt;
    logic [1:0]  outSel;
    logic [3:0]  outData;
    logic        outValid;
    logic        outBusy;

    mux_rr_sched #(.MAX_BURST(MAXB)) dut (
        .inClk(inClk), .inRstn(inRstn), .inReq(inReq), .inData(inData),
        .inLast(inLast), .inReady(inReady), .outAck(outAck), .outGnt(outGnt),
        .outSel(outSel), .outData(outData), .outValid(outValid), .outBusy(outBusy)
    );

    always #5 inClk = ~inClk;

    // Per-requester source queues: {last, nibble}.
    logic [4:0] srcq [4][$];
    bit         stall [4];
    int         nchk = 0;
    int         nerr = 0;

    // Reference model state.
    int         m_owner;
    int         m_ptr;
    int         m_cnt;
    int         m_sel;
    logic [3:0] m_data;
    logic       m_valid;
    logic [3:0] exp_ack;

    // Observation logs.
    int         grant_log[$];
    logic [3:0] data_log[$];
    int         ack_cnt[4];
    logic [3:0] prev_gnt;
    logic [3:0] last_ack;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 3;
        m_cnt   = 0;
        m_sel   = 0;
        m_data  = 4'h0;
        m_valid = 1'b0;
        prev_gnt = 4'b0000;
    endtask

    task automatic add_pkt(input int r, input int n, input bit with_last, input int base);
        for (int k = 0; k < n; k++) begin
            srcq[r].push_back({(with_last && (k == n - 1)) ? 1'b1 : 1'b0, 4'((base + k) & 15)});
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            inReq[i]         = (srcq[i].size() > 0) && !stall[i];
            inData[4*i +: 4] = (srcq[i].size() > 0) ? srcq[i][0][3:0] : 4'h0;
            inLast[i]        = (srcq[i].size() > 0) ? srcq[i][0][4] : 1'b0;
        end
    endtask

    // One clock cycle: drive, check the combinational ack, advance the model,
    // cross the rising edge, then check the registered outputs.
    task automatic cycle();
        bit found;
        bit lst;
        drive();
        #1;
        exp_ack = 4'b0000;
        if (m_owner >= 0 && inReq[m_owner] && (!m_valid || inReady)) exp_ack[m_owner] = 1'b1;
        chk("ack", 8'(outAck), 8'(exp_ack));
        last_ack = outAck;
        for (int i = 0; i < 4; i++) ack_cnt[i] += int'(outAck[i]);
        if (m_owner < 0) begin
            if (m_valid && inReady) m_valid = 1'b0;
            if (inReq != 4'b0000) begin
                found = 1'b0;
                for (int k = 1; k <= 4; k++) begin
                    if (!found && inReq[(m_ptr + k) % 4]) begin
                        m_owner = (m_ptr + k) % 4;
                        found   = 1'b1;
                    end
                end
                m_cnt = 0;
                m_sel = m_owner;
            end
        end else if (exp_ack != 4'b0000) begin
            m_data  = srcq[m_owner][0][3:0];
            lst     = srcq[m_owner][0][4];
            void'(srcq[m_owner].pop_front());
            m_valid = 1'b1;
            m_cnt++;
            if (lst || m_cnt == MAXB) begin
                m_ptr   = m_owner;
                m_owner = -1;
            end
        end else if (m_valid && inReady) begin
            m_valid = 1'b0;
        end
        @(posedge inClk);
        @(negedge inClk);
        chk("gnt", 8'(outGnt), (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00);
        chk("sel", 8'(outSel), 8'(m_sel));
        chk("data", 8'(outData), 8'(m_data));
        chk("valid", 8'(outValid), 8'(m_valid));
        chk("busy", 8'(outBusy), 8'(m_owner >= 0));
        if (exp_ack != 4'b0000) data_log.push_back(outData);
        if (outGnt != 4'b0000 && prev_gnt == 4'b0000) grant_log.push_back(int'(outSel));
        prev_gnt = outGnt;
    endtask

    function automatic bit pending();
        pending = (m_owner >= 0) || m_valid;
        for (int i = 0; i < 4; i++) if (srcq[i].size() > 0) pending = 1'b1;
    endfunction

    task automatic run_until_empty(input int budget, input string tag);
        int n;
        n = 0;
        while (pending() && n < budget) begin
            cycle();
            n++;
        end
        chk(tag, 8'(n >= budget), 8'h00);
    endtask

    task automatic clear_logs();
        grant_log.delete();
        data_log.delete();
        for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
    endtask

    initial begin
        logic [3:0] hold;
        int         n;
        int         acks2_at_switch;
        inRstn  = 1'b0;
        inReq   = 4'b0000;
        inData  = 16'h0000;
        inLast  = 4'b0000;
        inReady = 1'b1;
        for (int i = 0; i < 4; i++) stall[i] = 1'b0;
        model_reset();
        clear_logs();
        @(negedge inClk);
        @(negedge inClk);
        chk("rst_gnt", 8'(outGnt), 8'h00);
        chk("rst_sel", 8'(outSel), 8'h00);
        chk("rst_data", 8'(outData), 8'h00);
        chk("rst_valid", 8'(outValid), 8'h00);
        chk("rst_busy", 8'(outBusy), 8'h00);
        inRstn = 1'b1;
        cycle();

        // Round-robin: all four requesting, 2-beat packets.
        clear_logs();
        add_pkt(0, 2, 1'b1, 1);
        add_pkt(1, 2, 1'b1, 3);
        add_pkt(2, 2, 1'b1, 5);
        add_pkt(3, 2, 1'b1, 7);
        add_pkt(0, 2, 1'b1, 9);
        run_until_empty(60, "rr_timeout");
        chk("rr_ngrants", 8'(grant_log.size()), 8'd5);
        if (grant_log.size() == 5) begin
            chk("rr_g0", 8'(grant_log[0]), 8'd0);
            chk("rr_g1", 8'(grant_log[1]), 8'd1);
            chk("rr_g2", 8'(grant_log[2]), 8'd2);
            chk("rr_g3", 8'(grant_log[3]), 8'd3);
            chk("rr_g4", 8'(grant_log[4]), 8'd0);
        end

        // Single requester: A, B, C with last on C.
        clear_logs();
        srcq[0].push_back(5'h0A);
        srcq[0].push_back(5'h0B);
        srcq[0].push_back(5'h1C);
        cycle();
        chk("t1_gnt", 8'(outGnt), 8'h01);
        chk("t1_sel", 8'(outSel), 8'h00);
        chk("t1_novalid", 8'(outValid), 8'h00);
        cycle();
        chk("t1_dA", 8'(outData), 8'h0A);
        cycle();
        chk("t1_dB", 8'(outData), 8'h0B);
        cycle();
        chk("t1_dC", 8'(outData), 8'h0C);
        chk("t1_gnt_gap", 8'(outGnt), 8'h00);
        cycle();
        cycle();

        // Forced release: requester 2 streams 16 beats, requester 1 pending.
        clear_logs();
        add_pkt(2, 16, 1'b0, 0);
        cycle();
        add_pkt(1, 3, 1'b1, 12);
        n = 0;
        while (outGnt != 4'b0010 && n < 40) begin
            cycle();
            n++;
        end
        acks2_at_switch = ack_cnt[2];
        chk("fr_acks_before_switch", 8'(acks2_at_switch), 8'(MAXB));
        run_until_empty(80, "fr_timeout");
        chk("fr_acks2_total", 8'(ack_cnt[2]), 8'd16);
        chk("fr_acks1_total", 8'(ack_cnt[1]), 8'd3);
        chk("fr_ngrants", 8'(grant_log.size()), 8'd3);
        if (grant_log.size() == 3) chk("fr_regrant", 8'(grant_log[2]), 8'd2);

        // Backpressure: 5 cycles of inReady low mid-packet.
        clear_logs();
        add_pkt(0, 6, 1'b1, 4);
        cycle();
        cycle();
        cycle();
        hold = outData;
        inReady = 1'b0;
        for (int s = 0; s < 5; s++) begin
            cycle();
            chk("bp_data", 8'(outData), 8'(hold));
            chk("bp_valid", 8'(outValid), 8'h01);
            chk("bp_ack", 8'(last_ack), 8'h00);
        end
        inReady = 1'b1;
        run_until_empty(40, "bp_timeout");
        chk("bp_nbeats", 8'(data_log.size()), 8'd6);
        for (int k = 0; k < 6 && k < data_log.size(); k++)
            chk("bp_seq", 8'(data_log[k]), 8'((4 + k) & 15));

        // Stall without last: requester 1 drops inReq while 3 waits.
        clear_logs();
        add_pkt(1, 5, 1'b1, 2);
        cycle();
        cycle();
        cycle();
        add_pkt(3, 2, 1'b1, 13);
        stall[1] = 1'b1;
        for (int s = 0; s < 3; s++) begin
            cycle();
            chk("st_gnt_held", 8'(outGnt), 8'h02);
            chk("st_no_ack3", 8'(last_ack[3]), 8'h00);
        end
        stall[1] = 1'b0;
        run_until_empty(40, "st_timeout");
        chk("st_nbeats", 8'(data_log.size()), 8'd7);
        for (int k = 0; k < 5 && k < data_log.size(); k++)
            chk("st_seq1", 8'(data_log[k]), 8'(2 + k));
        if (data_log.size() == 7) begin
            chk("st_seq3a", 8'(data_log[5]), 8'd13);
            chk("st_seq3b", 8'(data_log[6]), 8'd14);
        end

        // Asynchronous reset in the middle of a burst.
        add_pkt(2, 6, 1'b1, 8);
        cycle();
        cycle();
        cycle();
        #2;
        inRstn = 1'b0;
        #1;
        chk("ar_gnt", 8'(outGnt), 8'h00);
        chk("ar_sel", 8'(outSel), 8'h00);
        chk("ar_data", 8'(outData), 8'h00);
        chk("ar_valid", 8'(outValid), 8'h00);
        chk("ar_busy", 8'(outBusy), 8'h00);
        chk("ar_ack", 8'(outAck), 8'h00);
        for (int i = 0; i < 4; i++) srcq[i].delete();
        model_reset();
        clear_logs();
        @(negedge inClk);
        inRstn = 1'b1;
        add_pkt(1, 2, 1'b1, 1);
        add_pkt(3, 2, 1'b1, 5);
        run_until_empty(40, "ar_timeout");
        chk("ar_ngrants", 8'(grant_log.size()), 8'd2);
        if (grant_log.size() > 0) chk("ar_first", 8'(grant_log[0]), 8'd1);

        // Random traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (srcq[i].size() == 0 && $urandom_range(0, 3) == 0)
                    add_pkt(i, int'($urandom_range(1, 11)), 1'b1, int'($urandom_range(0, 15)));
                stall[i] = ($urandom_range(0, 4) == 0);
            end
            inReady = ($urandom_range(0, 9) < 7);
            cycle();
        end
        for (int i = 0; i < 4; i++) stall[i] = 1'b0;
        inReady = 1'b1;
        run_until_empty(300, "rnd_timeout");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/mux_rr_sched.md
# mux_rr_sched

Round-robin scheduler that shares one 4-bit nibble channel between four requesters in the baseband datapath. It arbitrates between the requesters and drives the select of the 4:1 nibble multiplexer. It also owns the registered output stage with a valid/ready handshake toward the downstream consumer. Grants are packet-atomic, and a beat limit forces rotation so that no requester can starve the others.

## Interface
- MAX_BURST, 8, maximum beats per grant before forced release; legal range 1..255
- inClk  in  1  clock, all logic on rising edge
- inRstn  in  1  asynchronous active-low reset
- inReq  in  4  per-requester beat request; bit i = requester i has a valid nibble
- inData  in  16  requester data lanes; lane i = inData[4i+3:4i]
- inLast  in  4  per-requester last-beat flag, qualified by inReq[i]
- inReady  in  1  downstream ready for outData
- outAck  out  4  one-hot, combinational; pulses in the cycle requester i's beat is accepted
- outGnt  out  4  registered one-hot grant, 0 when no grant
- outSel  out  2  registered binary index of the granted requester (mux select)
- outData  out  4  registered selected nibble
- outValid  out  1  registered; outData holds an unconsumed beat
- outBusy  out  1  high while in state XFER

## Operation
- States: IDLE, XFER, plus a registered round-robin pointer ptr (2 bits) = last granted index.
- IDLE: if inReq != 0, pick the first set bit searching ptr+1, ptr+2, ptr+3, ptr (mod 4). Register outGnt/outSel to that index, clear the beat counter, and move to XFER. If inReq == 0, stay in IDLE with outGnt = 0.
- XFER, granted index g: load condition canLoad = (outValid == 0) || inReady.
- Accept = inReq[g] && canLoad. On accept:
  - outAck[g] = 1
  - outData <= lane g, outValid <= 1
  - beat counter += 1
- Release happens on accept when inLast[g] == 1 or counter + 1 == MAX_BURST. On release: ptr <= g, outGnt <= 0, state <= IDLE.
- Grant persists while inReq[g] is low without a last beat; other requesters wait (packet integrity).
- Output drain: if outValid && inReady and no accept this cycle, then outValid <= 0. outData is stable while outValid && !inReady.
- Non-granted requesters never see outAck; their inLast is ignored.
- Beat counter width is 8 bits and saturates logically via release; it never wraps.
- outBusy = (state == XFER).

## Timing
- Reset (async assert, sync-safe release) sets:
  - outGnt = 0, outSel = 0, outData = 0, outValid = 0, outBusy = 0
  - state = IDLE, counter = 0, ptr = 3, so requester 0 has top priority after reset
- Request seen in IDLE at edge N: outGnt valid after edge N; first accept possible in cycle N+1; outValid high after edge N+1. Request-to-data latency is 2 cycles.
- Back-to-back beats within a grant: 1 beat/cycle while inReady = 1.
- After release there is exactly one IDLE cycle (grant gap) before the next grant, even if requests are pending.
- Forced release at MAX_BURST: the requester keeps inReq high and re-competes. It is granted again only after every other pending requester in round-robin order.
- inReady low with outValid high: no accept, outAck = 0, and the grant and counter hold.
- Reset asserted mid-burst: all outputs clear immediately. The partially sent packet is dropped, and the first grant after reset goes to the lowest set inReq index starting at 0.
- Simultaneous release and drain: outValid stays 1 (new beat loaded); the next-cycle state is IDLE.

## Test plan
- Single requester: inReq = 4'b0001, lane0 = 4'hA, 4'hB, 4'hC with inLast on the third beat, inReady = 1.
  - outGnt = 0001, outSel = 0.
  - outData A, B, C on 3 consecutive cycles, starting 2 cycles after the request.
  - outGnt = 0 for one cycle afterwards.
- Round-robin: all four inReq held high, each packet 2 beats with inLast on beat 2.
  - Grant order is 0, 1, 2, 3, 0.
  - Exactly one IDLE gap cycle between grants.
  - outSel tracks outGnt.
- Forced release: MAX_BURST = 8, requester 2 sends 12 beats with no inLast, requester 1 is pending.
  - After 8 acks to requester 2, the grant goes to 1.
  - Requester 2 is regranted afterwards and the counter restarts at 0.
- Backpressure: hold inReady = 0 for 5 cycles mid-packet.
  - outValid stays 1, outData is stable, outAck = 0.
  - On inReady = 1, transfer resumes with no lost or duplicated nibble.
- Stall without last: the granted requester drops inReq for 3 cycles mid-packet while requester 3 requests.
  - Grant is held, requester 3 sees no outAck, and the packet completes in order.
- Async reset mid-burst: assert inRstn = 0 between edges.
  - All outputs go to 0 immediately.
  - After release with inReq = 4'b1010, the first grant is requester 1.
